oc_word_sequencer: RTL and testbench

OC_WORD_SEQUENCER -- requirements
Module: oc_word_sequencer

---
 rtl/oc_word_sequencer_if.sv | 25 ++
 rtl/oc_word_sequencer.sv | 109 ++++++++++
 tb/tb_oc_word_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/oc_word_sequencer_if.sv
// Stream interface for the word sequencer: word input handshake and
// result output handshake.
interface oc_word_sequencer_if #(
    parameter int W  = 12,
    parameter int CW = $clog2(W + 1)
);
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [CW-1:0] out_count;
    logic          out_ready;

    // Producer/consumer side (drives words in, takes results out)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count
    );
endinterface

// File: rtl/oc_word_sequencer.sv
// Ones-count sequencer: feeds an accepted word 3 bits at a time to an
// external combinational 3-input ones counter and accumulates the result.
module oc_word_sequencer #(
    parameter int W  = 12,
    parameter int CW = $clog2(W + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    oc_word_sequencer_if.slave   bus,
    output logic                 oc_a,
    output logic                 oc_b,
    output logic                 oc_c,
    input  logic                 oc_y1,
    input  logic                 oc_y0,
    output logic                 busy
);
    localparam int NCHUNK = W / 3;
    localparam int IW     = $clog2(NCHUNK + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          busy_q, busy_d;

    // Next-state logic: accept in IDLE, one chunk per edge in RUN, hold in DONE
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        case (state_q)
            S_IDLE: begin
                // in_ready_q is low for the first cycle after reset release
                if (in_ready_q && bus.in_valid) begin
                    sh_d    = bus.in_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_q + CW'({oc_y1, oc_y0});
                sh_d  = sh_q >> 3;
                idx_d = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_count_d = acc_d;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_count_d = '0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                out_count_d = '0;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    // State and registered outputs; reset discards any word in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            busy_q      <= busy_d;
        end
    end

    // Operand bits are only presented while a chunk is being counted
    assign oc_a = (state_q == S_RUN) & sh_q[2];
    assign oc_b = (state_q == S_RUN) & sh_q[1];
    assign oc_c = (state_q == S_RUN) & sh_q[0];

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_oc_word_sequencer.sv
// Self-checking bench for oc_word_sequencer: directed words plus random
// words, checked against a ones-count / chunk-order reference model.
module tb_oc_word_sequencer;
    localparam int W      = 12;
    localparam int CW     = $clog2(W + 1);
    localparam int NCHUNK = W / 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic oc_a, oc_b, oc_c, oc_y1, oc_y0, busy;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   accept_cyc = 0;
    int   prev_accept = 0;

    oc_word_sequencer_if #(.W(W), .CW(CW)) bus ();

    oc_word_sequencer #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .oc_a  (oc_a),
        .oc_b  (oc_b),
        .oc_c  (oc_c),
        .oc_y1 (oc_y1),
        .oc_y0 (oc_y0),
        .busy  (busy)
    );

    // External 3-input ones counter
    assign {oc_y1, oc_y0} = {1'b0, oc_a} + {1'b0, oc_b} + {1'b0, oc_c};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_oc"}, 32'({oc_a, oc_b, oc_c}), 32'd0);
    endtask

    // One complete transaction: accept, chunk sequence, result hold, release.
    task automatic send_word(input logic [W-1:0] word, input int hold,
                             input bit rdy_run, input bit noise);
        logic [W-1:0] w;
        int exp_cnt;
        w = word;
        exp_cnt = $countones(w);
        for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) @(negedge clk);
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(negedge clk);
        prev_accept = accept_cyc;
        accept_cyc  = cyc;
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        for (int k = 0; k < NCHUNK; k++) begin
            check("run_chunk_oc", 32'({oc_a, oc_b, oc_c}), 32'((w >> (3 * k)) & 7));
            check("run_out_valid", 32'(bus.out_valid), 32'd0);
            check("run_in_ready", 32'(bus.in_ready), 32'd0);
            check("run_busy", 32'(busy), 32'd1);
            bus.in_valid  = noise ? 1'($urandom % 2) : 1'b0;
            bus.in_data   = W'($urandom);
            bus.out_ready = rdy_run ? 1'b1 : 1'($urandom % 2);
            @(negedge clk);
        end
        for (int h = 0; h < hold; h++) begin
            check("done_out_valid", 32'(bus.out_valid), 32'd1);
            check("done_out_count", 32'(bus.out_count), 32'(exp_cnt));
            check("done_in_ready", 32'(bus.in_ready), 32'd0);
            check("done_oc", 32'({oc_a, oc_b, oc_c}), 32'd0);
            bus.out_ready = 1'b0;
            bus.in_valid  = noise ? 1'($urandom % 2) : 1'b0;
            bus.in_data   = W'($urandom);
            @(negedge clk);
        end
        check("result_valid", 32'(bus.out_valid), 32'd1);
        check("result_count", 32'(bus.out_count), 32'(exp_cnt));
        check("result_busy", 32'(busy), 32'd1);
        bus.out_ready = 1'b1;
        bus.in_valid  = noise ? 1'($urandom % 2) : 1'b0;
        @(negedge clk);
        bus.out_ready = rdy_run;
        bus.in_valid  = 1'b0;
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
        check("idle_out_count", 32'(bus.out_count), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_oc", 32'({oc_a, oc_b, oc_c}), 32'd0);
        $display("word=%03h expected_count=%0d accept_cycle=%0d hold=%0d", w, exp_cnt, accept_cyc, hold);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        check("post_release_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("post_release_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed words
        send_word(12'h000, 0, 1'b0, 1'b0);
        send_word(12'hFFF, 1, 1'b0, 1'b0);
        send_word(12'hA5A, 2, 1'b0, 1'b1);
        send_word(12'h0F0, 5, 1'b0, 1'b1);

        // Reset during the second RUN cycle
        bus.in_valid = 1'b1;
        bus.in_data  = 12'h0F3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pre_reset_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_quiet("mid_run_reset");
        @(negedge clk);
        check_quiet("mid_run_reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("no_stale_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        $display("reset during RUN checked at cycle=%0d", cyc);

        // Back-to-back with out_ready held high
        bus.out_ready = 1'b1;
        send_word(12'h001, 0, 1'b1, 1'b0);
        send_word(12'h800, 0, 1'b1, 1'b0);
        check("b2b_accept_gap", 32'(accept_cyc - prev_accept), 32'd6);
        bus.out_ready = 1'b0;

        // Random words with random hold and handshake noise
        for (int r = 0; r < 12; r++) begin
            send_word(W'($urandom), int'($urandom_range(0, 4)), 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
